regfile_hilo: RTL and testbench

- GPR file (32 x 32-bit) plus HI/LO special registers for the 54-instruction pipelined MIPS CPU.
- Receiving end of the write-back stage interface: it takes the rd and HI/LO write streams and commits them on the clock edge.
- Serves the decode stage through two combinational GPR read ports and HI/LO read ports, with same-cycle write-to-read bypass.
- Provides a debug read port for benches.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/regfile_hilo_hilo_reg.sv | 28 ++
 rtl/regfile_hilo.sv | 86 ++++++++
 tb/tb_regfile_hilo.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: datapath width, GPR addressing and symbolic register indices.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

  // Forwarding is only legal when built in and the register file is not being cleared.
  function automatic logic fwd_enable(input logic bypass, input logic rst);
    return bypass && !rst;
  endfunction

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// One HI or LO special register: sync-reset storage with an optional same-cycle write forward.
module hilo_reg #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wena,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] value;
  logic              fwd;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wena) begin
      value <= wdata;
    end
  end

  assign fwd   = fwd_enable(BYPASS, rst) && wena;
  assign rdata = fwd ? wdata : value;

endmodule

// File: rtl/regfile_hilo.sv
// 32-entry GPR file plus HI/LO for the MIPS pipeline: write-back commits on the edge,
// decode reads combinationally with optional same-cycle forwarding; debug port reads storage only.
module regfile_hilo #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_wena,
  input  logic [ADDR_W-1:0] rd_waddr,
  input  logic [DATA_W-1:0] rd_wdata,
  input  logic              hi_wena,
  input  logic              lo_wena,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  input  logic [ADDR_W-1:0] rs_raddr,
  input  logic [ADDR_W-1:0] rt_raddr,
  output logic [DATA_W-1:0] rs_rdata,
  output logic [DATA_W-1:0] rt_rdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);
  import cpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              gpr_we;
  logic              gpr_fwd;
  logic              rs_hit;
  logic              rt_hit;
  logic              rs_zero;
  logic              rt_zero;
  logic              dbg_zero;

  assign gpr_we = rd_wena && (rd_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (gpr_we) begin
      mem[rd_waddr] <= rd_wdata;
    end
  end

  // r0 is forced to zero on the read side so it holds even before the first reset.
  assign rs_zero  = (rs_raddr == '0);
  assign rt_zero  = (rt_raddr == '0);
  assign dbg_zero = (dbg_raddr == '0);

  assign gpr_fwd = fwd_enable(BYPASS, rst) && gpr_we;
  assign rs_hit  = gpr_fwd && (rs_raddr == rd_waddr);
  assign rt_hit  = gpr_fwd && (rt_raddr == rd_waddr);

  assign rs_rdata  = rs_zero  ? '0 : (rs_hit ? rd_wdata : mem[rs_raddr]);
  assign rt_rdata  = rt_zero  ? '0 : (rt_hit ? rd_wdata : mem[rt_raddr]);
  assign dbg_rdata = dbg_zero ? '0 : mem[dbg_raddr];

  hilo_reg #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_hi (
    .clk   (clk),
    .rst   (rst),
    .wena  (hi_wena),
    .wdata (hi_wdata),
    .rdata (hi_rdata)
  );

  hilo_reg #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_lo (
    .clk   (clk),
    .rst   (rst),
    .wena  (lo_wena),
    .wdata (lo_wdata),
    .rdata (lo_rdata)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo: directed scenarios plus randomized traffic against an array model.
module tb_regfile_hilo;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_wena;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        hi_wena;
  logic        lo_wena;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic [4:0]  rs_raddr;
  logic [4:0]  rt_raddr;
  logic [31:0] rs_rdata;
  logic [31:0] rt_rdata;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] ref_gpr [32];
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  regfile_hilo #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_wena   (rd_wena),
    .rd_waddr  (rd_waddr),
    .rd_wdata  (rd_wdata),
    .hi_wena   (hi_wena),
    .lo_wena   (lo_wena),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .rs_raddr  (rs_raddr),
    .rt_raddr  (rt_raddr),
    .rs_rdata  (rs_rdata),
    .rt_rdata  (rt_rdata),
    .hi_rdata  (hi_rdata),
    .lo_rdata  (lo_rdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected view of a decode read port: r0 is zero, a live write forwards unless in reset.
  function automatic logic [31:0] exp_port(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst && rd_wena && rd_waddr != 5'd0 && a == rd_waddr) return rd_wdata;
    return ref_gpr[a];
  endfunction

  function automatic logic [31:0] exp_hi();
    return (!rst && hi_wena) ? hi_wdata : ref_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    return (!rst && lo_wena) ? lo_wdata : ref_lo;
  endfunction

  // Apply the current inputs to the model, then advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
      ref_hi = 32'h0;
      ref_lo = 32'h0;
    end else begin
      if (rd_wena && rd_waddr != 5'd0) ref_gpr[rd_waddr] = rd_wdata;
      if (hi_wena) ref_hi = hi_wdata;
      if (lo_wena) ref_lo = lo_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst      = 1'b0;
    rd_wena  = 1'b0;
    rd_waddr = 5'd0;
    rd_wdata = 32'h0;
    hi_wena  = 1'b0;
    lo_wena  = 1'b0;
    hi_wdata = 32'h0;
    lo_wdata = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    rs_raddr = 5'd0; rt_raddr = 5'd0; dbg_raddr = 5'd0;
    rst = 1'b1;
    tick();
    tick();
    idle();
    rd_wena = 1'b1; rd_waddr = 5'd5; rd_wdata = 32'h1234;
    hi_wena = 1'b1; hi_wdata = 32'hFFFF0000;
    tick();
    idle();
    rs_raddr = 5'd5;
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h1234) $display("FAIL preload_r5: got %h want %h", rs_rdata, 32'h1234);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    idle();
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h0) $display("FAIL reset_r5: got %h want 0", rs_rdata);
    else pass_cnt++;
    total_cnt++;
    if (hi_rdata !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi_rdata);
    else pass_cnt++;
    total_cnt++;
    if (lo_rdata !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo_rdata);
    else pass_cnt++;
    for (int i = 1; i < 32; i++) begin
      dbg_raddr = 5'(i);
      #1;
      total_cnt++;
      if (dbg_rdata !== 32'h0) $display("FAIL reset_dbg_r%0d: got %h want 0", i, dbg_rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    idle();
    rd_wena = 1'b1; rd_waddr = 5'd7; rd_wdata = 32'hDEADBEEF;
    tick();
    idle();
    rs_raddr = 5'd7; rt_raddr = 5'd7; dbg_raddr = 5'd7;
    #1;
    total_cnt++;
    if (rs_rdata !== 32'hDEADBEEF) $display("FAIL wr_rs_r7: got %h want %h", rs_rdata, 32'hDEADBEEF);
    else pass_cnt++;
    total_cnt++;
    if (rt_rdata !== 32'hDEADBEEF) $display("FAIL wr_rt_r7: got %h want %h", rt_rdata, 32'hDEADBEEF);
    else pass_cnt++;
    total_cnt++;
    if (dbg_rdata !== 32'hDEADBEEF) $display("FAIL wr_dbg_r7: got %h want %h", dbg_rdata, 32'hDEADBEEF);
    else pass_cnt++;
  endtask

  task automatic test_r0_protect();
    idle();
    rd_wena = 1'b1; rd_waddr = 5'd0; rd_wdata = 32'hFFFFFFFF;
    rs_raddr = 5'd0; rt_raddr = 5'd0; dbg_raddr = 5'd0;
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h0) $display("FAIL r0_rs_same_cycle: got %h want 0", rs_rdata);
    else pass_cnt++;
    total_cnt++;
    if (rt_rdata !== 32'h0) $display("FAIL r0_rt_same_cycle: got %h want 0", rt_rdata);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h0) $display("FAIL r0_rs_after: got %h want 0", rs_rdata);
    else pass_cnt++;
    total_cnt++;
    if (dbg_rdata !== 32'h0) $display("FAIL r0_dbg_after: got %h want 0", dbg_rdata);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle();
    rd_wena = 1'b1; rd_waddr = 5'd3; rd_wdata = 32'h11;
    tick();
    rd_wdata = 32'h22;
    rs_raddr = 5'd3; rt_raddr = 5'd3; dbg_raddr = 5'd3;
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h22) $display("FAIL byp_rs_r3: got %h want %h", rs_rdata, 32'h22);
    else pass_cnt++;
    total_cnt++;
    if (rt_rdata !== 32'h22) $display("FAIL byp_rt_r3: got %h want %h", rt_rdata, 32'h22);
    else pass_cnt++;
    total_cnt++;
    if (dbg_rdata !== 32'h11) $display("FAIL byp_dbg_before: got %h want %h", dbg_rdata, 32'h11);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (dbg_rdata !== 32'h22) $display("FAIL byp_dbg_after: got %h want %h", dbg_rdata, 32'h22);
    else pass_cnt++;
  endtask

  task automatic test_hilo();
    idle();
    lo_wena = 1'b1; lo_wdata = 32'h0BADF00D;
    tick();
    idle();
    hi_wena = 1'b1; hi_wdata = 32'hA5A5A5A5;
    lo_wdata = 32'h5A5A5A5A;
    #1;
    total_cnt++;
    if (hi_rdata !== 32'hA5A5A5A5) $display("FAIL hi_bypass: got %h want %h", hi_rdata, 32'hA5A5A5A5);
    else pass_cnt++;
    total_cnt++;
    if (lo_rdata !== 32'h0BADF00D) $display("FAIL lo_unchanged: got %h want %h", lo_rdata, 32'h0BADF00D);
    else pass_cnt++;
    tick();
    idle();
    hi_wena = 1'b1; hi_wdata = 32'h1;
    lo_wena = 1'b1; lo_wdata = 32'h2;
    #1;
    total_cnt++;
    if (hi_rdata !== 32'h1 || lo_rdata !== 32'h2)
      $display("FAIL hilo_both_bypass: got %h/%h want 1/2", hi_rdata, lo_rdata);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (hi_rdata !== 32'h1 || lo_rdata !== 32'h2)
      $display("FAIL hilo_both_after: got %h/%h want 1/2", hi_rdata, lo_rdata);
    else pass_cnt++;
  endtask

  task automatic test_named_regs();
    idle();
    rd_wena = 1'b1; rd_waddr = REG_SP; rd_wdata = 32'h7FFF_EFFC;
    tick();
    rd_waddr = REG_RA; rd_wdata = 32'h0040_0018;
    tick();
    idle();
    rs_raddr = REG_SP; rt_raddr = REG_RA;
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h7FFF_EFFC || rt_rdata !== 32'h0040_0018)
      $display("FAIL sp_ra_read: got %h/%h want 7fffeffc/00400018", rs_rdata, rt_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_vs_write();
    idle();
    rd_wena = 1'b1; rd_waddr = 5'd9; rd_wdata = 32'h99;
    hi_wena = 1'b1; hi_wdata = 32'h33;
    tick();
    idle();
    rst = 1'b1;
    rd_wena = 1'b1; rd_waddr = 5'd9; rd_wdata = 32'h55;
    hi_wena = 1'b1; hi_wdata = 32'h77;
    rs_raddr = 5'd9; rt_raddr = 5'd9; dbg_raddr = 5'd9;
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h99) $display("FAIL rst_no_bypass_rs: got %h want %h", rs_rdata, 32'h99);
    else pass_cnt++;
    total_cnt++;
    if (hi_rdata !== 32'h33) $display("FAIL rst_no_bypass_hi: got %h want %h", hi_rdata, 32'h33);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (rs_rdata !== 32'h0 || rt_rdata !== 32'h0 || hi_rdata !== 32'h0 || lo_rdata !== 32'h0)
      $display("FAIL rst_held_reads: got %h/%h/%h/%h want all 0", rs_rdata, rt_rdata, hi_rdata, lo_rdata);
    else pass_cnt++;
    idle();
    tick();
    #1;
    total_cnt++;
    if (dbg_rdata !== 32'h0 || hi_rdata !== 32'h0)
      $display("FAIL rst_write_dropped: got r9=%h hi=%h want 0/0", dbg_rdata, hi_rdata);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      rd_wena  = $urandom_range(0, 1);
      rd_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rd_wdata = $urandom;
      hi_wena  = ($urandom_range(0, 3) == 0);
      lo_wena  = ($urandom_range(0, 3) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      rs_raddr = ($urandom_range(0, 2) == 0) ? rd_waddr : 5'($urandom_range(0, 31));
      rt_raddr = ($urandom_range(0, 2) == 0) ? rd_waddr : 5'($urandom_range(0, 31));
      dbg_raddr = 5'($urandom_range(0, 31));
      #1;
      e = exp_port(rs_raddr);
      total_cnt++;
      if (rs_rdata !== e) $display("FAIL rand_rs[%0d] a=%0d: got %h want %h", n, rs_raddr, rs_rdata, e);
      else pass_cnt++;
      e = exp_port(rt_raddr);
      total_cnt++;
      if (rt_rdata !== e) $display("FAIL rand_rt[%0d] a=%0d: got %h want %h", n, rt_raddr, rt_rdata, e);
      else pass_cnt++;
      e = exp_hi();
      total_cnt++;
      if (hi_rdata !== e) $display("FAIL rand_hi[%0d]: got %h want %h", n, hi_rdata, e);
      else pass_cnt++;
      e = exp_lo();
      total_cnt++;
      if (lo_rdata !== e) $display("FAIL rand_lo[%0d]: got %h want %h", n, lo_rdata, e);
      else pass_cnt++;
      e = ref_gpr[dbg_raddr];
      total_cnt++;
      if (dbg_rdata !== e) $display("FAIL rand_dbg[%0d] a=%0d: got %h want %h", n, dbg_raddr, dbg_rdata, e);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
    ref_hi = 32'h0;
    ref_lo = 32'h0;
    idle();
    rs_raddr = 5'd0; rt_raddr = 5'd0; dbg_raddr = 5'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_r0_protect();
    test_bypass();
    test_hilo();
    test_named_regs();
    test_reset_vs_write();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
